// File: rtl/systolic_tile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | systolic_tile_sequencer: byte-stream loader, array reset/run window and  |
// | 2x2 result capture for the 3x3 systolic convolution array.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module systolic_tile_sequencer #(
  parameter int COMPUTE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         keep_filter,
  output logic [127:0] img_flat,
  output logic [71:0]  filt_flat,
  output logic         array_rst,
  input  logic [31:0]  arr_res,
  output logic [31:0]  res_out,
  output logic         res_valid,
  output logic         tile_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_F = 2'd1,
    LOAD_I = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic [7:0] RUN_LAST  = 8'(COMPUTE_CYCLES - 1);
  localparam logic [4:0] FILT_LAST = 5'd8;
  localparam logic [4:0] IMG_LAST  = 5'd15;

  state_t        state;
  state_t        state_next;
  logic [4:0]    byte_cnt;
  logic [7:0]    run_cnt;
  logic [71:0]   filt_q;
  logic [127:0]  img_q;
  logic [31:0]   res_q;
  logic          res_valid_q;
  logic          tile_done_q;
  logic          accept;
  logic          run_last;

  assign in_ready  = !rst && (state != RUN);
  assign accept    = in_valid && in_ready;
  assign run_last  = (run_cnt == RUN_LAST);

  assign img_flat  = img_q;
  assign filt_flat = filt_q;
  assign res_out   = res_q;
  assign res_valid = res_valid_q;
  assign tile_done = tile_done_q;
  assign busy      = (state != IDLE);
  assign array_rst = (state != RUN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = keep_filter ? LOAD_I : LOAD_F;
      LOAD_F:  if (accept && byte_cnt == FILT_LAST) state_next = LOAD_I;
      LOAD_I:  if (accept && byte_cnt == IMG_LAST) state_next = RUN;
      RUN:     if (run_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Filter/image storage persists across tiles so keep_filter tiles reuse it.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt    <= 5'd0;
      run_cnt     <= 8'd0;
      filt_q      <= '0;
      img_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            res_valid_q <= 1'b0;
            byte_cnt    <= 5'd1;
            if (keep_filter) img_q[7:0]  <= in_data;
            else             filt_q[7:0] <= in_data;
          end
        end
        LOAD_F: begin
          if (accept) begin
            for (int k = 0; k < 9; k++)
              if (byte_cnt == 5'(k)) filt_q[8*k +: 8] <= in_data;
            byte_cnt <= (byte_cnt == FILT_LAST) ? 5'd0 : byte_cnt + 5'd1;
          end
        end
        LOAD_I: begin
          if (accept) begin
            for (int k = 0; k < 16; k++)
              if (byte_cnt == 5'(k)) img_q[8*k +: 8] <= in_data;
            if (byte_cnt == IMG_LAST) begin
              byte_cnt <= 5'd0;
              run_cnt  <= 8'd0;
            end else begin
              byte_cnt <= byte_cnt + 5'd1;
            end
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 8'd1;
          if (run_last) begin
            res_q       <= arr_res;
            res_valid_q <= 1'b1;
            tile_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
